// File: rtl/seq_serializer.sv
// ---------------------------------------------------------------------------
// seq_serializer
// Parallel-to-serial front end for the serial pattern detector. WIDTH-bit
// words arrive over a valid/ready handshake into a one-word holding register
// and are shifted out one bit per clock on dout. While a word is shifting,
// the next one can wait in the holding register, so consecutive words leave
// with no gap bits between them.
//
// Ports:
//   clk        system clock, all state changes on the rising edge
//   rst_n      asynchronous active-low reset
//   flush      synchronous clear of held and in-flight data
//   data_in    parallel word
//   data_valid data_in is valid
//   data_ready holding register empty, a word can be accepted
//   dout       serial bit, drives the detector's din
//   dout_valid dout carries a data bit rather than idle fill
//   word_done  one-cycle pulse alongside the last bit of each word
//   busy       shifter active or holding register full
// ---------------------------------------------------------------------------
module seq_serializer #(
    parameter int   WIDTH     = 8,
    parameter int   MSB_FIRST = 1,
    parameter logic IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             word_done,
    output logic             busy
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] hold_reg;
    logic             hold_full;
    logic [WIDTH-1:0] shift_reg;
    logic [CNT_W-1:0] bit_cnt;

    logic             accept;
    logic             load_word;
    logic             load_first;
    logic [WIDTH-1:0] load_rest;
    logic             next_bit;
    logic [WIDTH-1:0] shift_rest;

    // A transfer needs the registered ready; it cannot coincide with a hold
    // move because ready is low whenever the hold register is full.
    assign accept = data_valid & data_ready;

    // The held word moves into the shifter either from idle or on the edge
    // after the previous word's last bit, which keeps the bit stream gapless.
    assign load_word = hold_full & ((state == IDLE) | (bit_cnt == '0));

    assign busy = (state == SHIFT) | hold_full;

    // Bit-order selection: the shifter always holds the bits still to be
    // sent, already aligned so the next one sits at the output end.
    always_comb begin
        load_first = hold_reg[0];
        load_rest  = hold_reg >> 1;
        next_bit   = shift_reg[0];
        shift_rest = shift_reg >> 1;
        if (MSB_FIRST != 0) begin
            load_first = hold_reg[WIDTH-1];
            load_rest  = hold_reg << 1;
            next_bit   = shift_reg[WIDTH-1];
            shift_rest = shift_reg << 1;
        end
    end

    // Holding register and handshake. data_ready always mirrors the value
    // hold_full takes at the same edge, so it reads as ~hold_full from the
    // first edge after reset onwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_reg   <= '0;
            hold_full  <= 1'b0;
            data_ready <= 1'b0;
        end else if (flush) begin
            hold_full  <= 1'b0;
            data_ready <= 1'b1;
        end else if (accept) begin
            hold_reg   <= data_in;
            hold_full  <= 1'b1;
            data_ready <= 1'b0;
        end else if (load_word) begin
            hold_full  <= 1'b0;
            data_ready <= 1'b1;
        end else begin
            data_ready <= ~hold_full;
        end
    end

    // Shifter state machine. bit_cnt counts the bits still to follow the one
    // currently on dout; word_done is raised by the edge that puts the final
    // bit out, i.e. the edge leaving bit_cnt at 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            shift_reg  <= '0;
            bit_cnt    <= '0;
            dout       <= IDLE_BIT;
            dout_valid <= 1'b0;
            word_done  <= 1'b0;
        end else if (flush) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            dout       <= IDLE_BIT;
            dout_valid <= 1'b0;
            word_done  <= 1'b0;
        end else begin
            word_done <= 1'b0;
            if (load_word) begin
                state      <= SHIFT;
                shift_reg  <= load_rest;
                bit_cnt    <= CNT_W'(WIDTH - 1);
                dout       <= load_first;
                dout_valid <= 1'b1;
            end else if (state == SHIFT) begin
                if (bit_cnt != '0) begin
                    shift_reg <= shift_rest;
                    bit_cnt   <= bit_cnt - CNT_W'(1);
                    dout      <= next_bit;
                    word_done <= (bit_cnt == CNT_W'(1));
                end else begin
                    state      <= IDLE;
                    dout       <= IDLE_BIT;
                    dout_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_serializer.sv
// ---------------------------------------------------------------------------
// tb_seq_serializer
// Scoreboard bench for seq_serializer. Two instances share all inputs: one
// MSB-first, one LSB-first. The driver pushes one queue entry per expected
// output bit (the cycle it must appear in, the word and the bit index) each
// time a word is accepted; a monitor on the falling edge pops and compares.
// ---------------------------------------------------------------------------
module tb_seq_serializer;

    localparam int W = 8;
    localparam logic IDLE = 1'b0;

    typedef struct {
        int         cycle;
        logic [W-1:0] word;
        int         idx;
    } bit_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush = 1'b0;
    logic [W-1:0] data_in = '0;
    logic         data_valid = 1'b0;

    logic data_ready, dout, dout_valid, word_done, busy;
    logic l_data_ready, l_dout, l_dout_valid, l_word_done, l_busy;

    int nChecks = 0;
    int nErrors = 0;
    int cyc = 0;
    int readyFrom = 1 << 30;
    int holdUntil = 0;
    int nextFree = 0;
    bit monOn = 1'b0;
    bit pendAccept = 1'b0;
    bit pendFlush = 1'b0;
    logic [W-1:0] pendWord = '0;
    bit_t q[$];

    seq_serializer #(.WIDTH(W), .MSB_FIRST(1), .IDLE_BIT(IDLE)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .data_in(data_in),
        .data_valid(data_valid), .data_ready(data_ready), .dout(dout),
        .dout_valid(dout_valid), .word_done(word_done), .busy(busy)
    );

    seq_serializer #(.WIDTH(W), .MSB_FIRST(0), .IDLE_BIT(IDLE)) dut_lsb (
        .clk(clk), .rst_n(rst_n), .flush(flush), .data_in(data_in),
        .data_valid(data_valid), .data_ready(l_data_ready), .dout(l_dout),
        .dout_valid(l_dout_valid), .word_done(l_word_done), .busy(l_busy)
    );

    always #5 clk = ~clk;

    // Watchdog so the bench can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference: the hold register is free once the word's first bit has
    // left, and ready only becomes visible from the first edge after reset.
    function automatic bit modelReady();
        return (cyc >= readyFrom) && (cyc >= holdUntil);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nErrors++;
            $display("[TB] FAIL %s at cycle %0d: actual=%0h required=%0h",
                     name, cyc, actual, expected);
        end
    endtask

    task automatic clearModel();
        q.delete();
        holdUntil = 0;
        nextFree  = 0;
    endtask

    // One clock of stimulus. The edge just passed commits whatever the
    // previous call set up; new inputs are then driven 2 ns after the edge.
    task automatic applyStimulus(input bit valid, input logic [W-1:0] word,
                                 input bit fl);
        int start;
        @(posedge clk);
        cyc++;
        if (pendFlush) begin
            clearModel();
        end else if (pendAccept) begin
            start = (cyc + 1 > nextFree) ? cyc + 1 : nextFree;
            for (int i = 0; i < W; i++) begin
                q.push_back('{cycle: start + i, word: pendWord, idx: i});
            end
            holdUntil = start;
            nextFree  = start + W;
        end
        #2;
        data_valid = valid;
        data_in    = word;
        flush      = fl;
        pendFlush  = fl;
        pendWord   = word;
        pendAccept = valid && !fl && modelReady();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0);
    endtask

    // Holds a word on the bus until the model says it is taken.
    task automatic sendWord(input logic [W-1:0] word);
        bit taken;
        taken = 1'b0;
        for (int i = 0; i < 40 && !taken; i++) begin
            applyStimulus(1'b1, word, 1'b0);
            taken = pendAccept;
        end
        checkOutput("accept_timeout", {31'd0, taken}, 32'd1);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_dout"}, {31'd0, dout}, {31'd0, IDLE});
        checkOutput({tag, "_dout_valid"}, {31'd0, dout_valid}, 32'd0);
        checkOutput({tag, "_word_done"}, {31'd0, word_done}, 32'd0);
        checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
        checkOutput({tag, "_data_ready"}, {31'd0, data_ready}, 32'd0);
        checkOutput({tag, "_lsb_dout_valid"}, {31'd0, l_dout_valid}, 32'd0);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic pulseReset();
        #1;
        rst_n      = 1'b0;
        data_valid = 1'b0;
        flush      = 1'b0;
        pendAccept = 1'b0;
        pendFlush  = 1'b0;
        #1;
        checkResetValues("midreset");
        clearModel();
        @(posedge clk);
        cyc++;
        #3;
        rst_n     = 1'b1;
        readyFrom = cyc + 1;
    endtask

    // Monitor: every falling edge, compare both instances against the
    // scoreboard entry due in this cycle, or against idle fill if none is.
    always @(negedge clk) begin
        if (rst_n && monOn) begin
            logic eBusy;
            logic eReady;
            bit_t e;
            eBusy  = (q.size() > 0);
            eReady = modelReady();
            checkOutput("busy", {31'd0, busy}, {31'd0, eBusy});
            checkOutput("lsb_busy", {31'd0, l_busy}, {31'd0, eBusy});
            checkOutput("data_ready", {31'd0, data_ready}, {31'd0, eReady});
            checkOutput("lsb_data_ready", {31'd0, l_data_ready}, {31'd0, eReady});
            if (q.size() > 0 && q[0].cycle == cyc) begin
                e = q.pop_front();
                checkOutput("dout_valid", {31'd0, dout_valid}, 32'd1);
                checkOutput("dout", {31'd0, dout}, {31'd0, e.word[W-1-e.idx]});
                checkOutput("word_done", {31'd0, word_done},
                            (e.idx == W - 1) ? 32'd1 : 32'd0);
                checkOutput("lsb_dout_valid", {31'd0, l_dout_valid}, 32'd1);
                checkOutput("lsb_dout", {31'd0, l_dout}, {31'd0, e.word[e.idx]});
                checkOutput("lsb_word_done", {31'd0, l_word_done},
                            (e.idx == W - 1) ? 32'd1 : 32'd0);
            end else begin
                checkOutput("idle_dout_valid", {31'd0, dout_valid}, 32'd0);
                checkOutput("idle_dout", {31'd0, dout}, {31'd0, IDLE});
                checkOutput("idle_word_done", {31'd0, word_done}, 32'd0);
                checkOutput("lsb_idle_dout_valid", {31'd0, l_dout_valid}, 32'd0);
                checkOutput("lsb_idle_dout", {31'd0, l_dout}, {31'd0, IDLE});
            end
        end
    end

    // Main sequence: directed scenarios first, then random traffic.
    initial begin
        #3;
        checkResetValues("reset");
        // A handshake offered during reset must be ignored.
        data_valid = 1'b1;
        data_in    = 8'hE7;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            cyc++;
        end
        #3;
        data_valid = 1'b0;
        rst_n      = 1'b1;
        readyFrom  = cyc + 1;
        monOn      = 1'b1;

        idle(10);

        sendWord(8'h6D);
        idle(10);

        sendWord(8'hA5);
        sendWord(8'h3C);
        idle(20);

        sendWord(8'h01);
        idle(10);

        // Flush after three bits of 8'hFF while 8'h12 waits in the hold.
        sendWord(8'hFF);
        sendWord(8'h12);
        applyStimulus(1'b0, '0, 1'b0);
        applyStimulus(1'b0, '0, 1'b1);
        idle(12);

        // Reset pulse in the middle of a word, then a clean word.
        sendWord(8'hC3);
        idle(3);
        pulseReset();
        idle(2);
        sendWord(8'h96);
        idle(12);

        for (int i = 0; i < 500; i++) begin
            applyStimulus(($urandom % 4) != 0, W'($urandom),
                          ($urandom % 50) == 0);
        end
        idle(25);
        checkOutput("drain", q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nErrors);
        $finish;
    end

endmodule
